ro_puf_eval_ctrl: RTL

- Sequences challenge evaluation of the RO PUF array, one oscillator pair at a time.
- Per pair: selects the pair and clears the two frequency counters. Then enables the oscillators for a fixed gate window, waits for counter outputs to settle, and samples the 16-bit count comparator result into a response register.
- Sits between the top-level PUF interface (start/response) and the RO mux, counter and comparator datapath.

---
 rtl/ro_puf_pkg.sv | 24 ++
 rtl/ro_puf_window_timer.sv | 27 ++
 rtl/ro_puf_eval_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the RO PUF evaluation controller.
// Optional feature macro: RO_PUF_VOTE_EN (majority vote over repeated evaluations).
package ro_puf_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int unsigned VOTE_COUNT = 3;

    // Wide enough to hold the larger of the two reload values.
    function automatic int unsigned timer_width(input int unsigned window,
                                                input int unsigned settle);
        int unsigned mx;
        mx = (window > settle) ? window : settle;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/ro_puf_window_timer.sv
// Loadable down-counter; expired pulses for one cycle in the last cycle of the
// loaded duration, so a load of N gives exactly N cycles before expiry is acted on.
module ro_puf_window_timer #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == W'(1));

endmodule

// File: rtl/ro_puf_eval_ctrl.sv
// Challenge evaluation sequencer for the RO PUF array: one oscillator pair at a time.
// Optional feature macro: RO_PUF_VOTE_EN (3 evaluations per pair, majority vote).
module ro_puf_eval_ctrl
    import ro_puf_pkg::*;
#(
    parameter int unsigned NUM_PAIRS     = 8,
    parameter int unsigned WINDOW_CYCLES = 1000,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SEL_W         = $clog2(2 * NUM_PAIRS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 A_is_larger,
    output logic [SEL_W-1:0]     ro_sel_A,
    output logic [SEL_W-1:0]     ro_sel_B,
    output logic                 cnt_clr,
    output logic                 ro_en,
    output logic                 busy,
    output logic                 done,
    output logic                 resp_valid,
    output logic [NUM_PAIRS-1:0] response
);

    localparam int unsigned PAIR_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int unsigned TMR_W  = timer_width(WINDOW_CYCLES, SETTLE_CYCLES);
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_PAIRS - 1);

    state_t              state;
    logic [PAIR_W-1:0]   pair;
    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_expired;
    logic                last_eval;
    logic                capture_bit;

    // One timer serves both RUN and SETTLE; SETTLE is loaded on the RUN expiry edge.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (state == CLEAR) begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(WINDOW_CYCLES);
        end else if (state == RUN && tmr_expired) begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(SETTLE_CYCLES);
        end
    end

    ro_puf_window_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .expired (tmr_expired)
    );

`ifdef RO_PUF_VOTE_EN
    logic [1:0] eval_cnt;
    logic [1:0] votes;
    logic [1:0] votes_next;

    assign votes_next  = votes + {1'b0, A_is_larger};
    assign last_eval   = (eval_cnt == 2'(VOTE_COUNT - 1));
    assign capture_bit = (votes_next >= 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eval_cnt <= '0;
            votes    <= '0;
        end else if (state == IDLE && start) begin
            eval_cnt <= '0;
            votes    <= '0;
        end else if (state == CAPTURE) begin
            if (last_eval) begin
                eval_cnt <= '0;
                votes    <= '0;
            end else begin
                eval_cnt <= eval_cnt + 2'd1;
                votes    <= votes_next;
            end
        end
    end
`else
    assign last_eval   = 1'b1;
    assign capture_bit = A_is_larger;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pair       <= '0;
            ro_sel_A   <= '0;
            ro_sel_B   <= SEL_W'(1);
            cnt_clr    <= 1'b0;
            ro_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            resp_valid <= 1'b0;
            response   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= CLEAR;
                        pair       <= '0;
                        ro_sel_A   <= '0;
                        ro_sel_B   <= SEL_W'(1);
                        response   <= '0;
                        resp_valid <= 1'b0;
                        cnt_clr    <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                CLEAR: begin
                    state   <= RUN;
                    cnt_clr <= 1'b0;
                    ro_en   <= 1'b1;
                end
                RUN: begin
                    if (tmr_expired) begin
                        state <= SETTLE;
                        ro_en <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (tmr_expired) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (!last_eval) begin
                        state   <= CLEAR;
                        cnt_clr <= 1'b1;
                    end else begin
                        response[pair] <= capture_bit;
                        if (pair == LAST_PAIR) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= CLEAR;
                            pair     <= pair + PAIR_W'(1);
                            ro_sel_A <= SEL_W'({pair + PAIR_W'(1), 1'b0});
                            ro_sel_B <= SEL_W'({pair + PAIR_W'(1), 1'b1});
                            cnt_clr  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    done       <= 1'b0;
                    resp_valid <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
